// File: rtl/spi_regfile_pkg.sv
// Shared FSM encoding and command-byte field positions for the SPI register file.
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_CS,
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DISCARD
  } state_e;

  localparam int unsigned CMD_RD_BIT   = 7;
  localparam int unsigned CMD_ADDR_MSB = 6;
  localparam logic [7:0]  ERR_MAX      = 8'hFF;

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop synchronizer for the raw SPI chip select, with rise/fall pulses of the
// synchronized level. All flops reset to the deasserted (high) level.
module spi_cs_sync (
  input  logic system_clk,
  input  logic system_rst,
  input  logic spi_cs,
  output logic cs_n_s,
  output logic cs_rise_c,
  output logic cs_fall_c
);

  logic cs_meta;
  logic cs_prev;

  always_ff @(posedge system_clk) begin
    if (system_rst) begin
      cs_meta <= 1'b1;
      cs_n_s  <= 1'b1;
      cs_prev <= 1'b1;
    end else begin
      cs_meta <= spi_cs;
      cs_n_s  <= cs_meta;
      cs_prev <= cs_n_s;
    end
  end

  assign cs_rise_c = cs_n_s & ~cs_prev;
  assign cs_fall_c = ~cs_n_s & cs_prev;

endmodule

// File: rtl/spi_cmd_regfile.sv
// Parses CS-delimited SPI byte frames into register writes / read-pointer loads.
// Optional SPI_REGFILE_STATUS_EN makes the top register a read-only status byte.
module spi_cmd_regfile
  import spi_regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                  system_clk,
  input  logic                  system_rst,
  input  logic                  spi_cs,
  input  logic                  spi_data_ready,
  input  logic [7:0]            spi_rx_data,
  output logic                  spi_read_ack,
  output logic [7:0]            data_to_send,
  output logic [NUM_REGS*8-1:0] reg_bank,
  output logic                  reg_wr_strobe,
  output logic [ADDR_W-1:0]     reg_wr_addr,
  output logic [7:0]            reg_wr_data,
  output logic                  frame_done,
  output logic [7:0]            err_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_e            state;
  logic [7:0]        regs [NUM_REGS];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              ready_d;
  logic [1:0]        settle;
  logic              cs_n_s;
  logic              cs_rise_c;
  logic              cs_fall_c;
  logic              in_frame_c;
  logic              consume_c;
  logic              addr_bad_c;
  logic              wr_allowed_c;
  logic [CMD_ADDR_MSB:0] cmd_addr_c;

  spi_cs_sync u_cs_sync (
    .system_clk (system_clk),
    .system_rst (system_rst),
    .spi_cs     (spi_cs),
    .cs_n_s     (cs_n_s),
    .cs_rise_c  (cs_rise_c),
    .cs_fall_c  (cs_fall_c)
  );

  // A byte is taken once per ready assertion; the slave drops ready a cycle after ack.
  assign in_frame_c = (state == ST_CMD) || (state == ST_DATA) || (state == ST_DISCARD);
  assign consume_c  = spi_data_ready && !ready_d && !spi_read_ack && in_frame_c;
  assign cmd_addr_c = spi_rx_data[CMD_ADDR_MSB:0];
  assign addr_bad_c = 8'(cmd_addr_c) >= 8'(NUM_REGS);

`ifdef SPI_REGFILE_STATUS_EN
  logic [3:0] frame_cnt;

  always_ff @(posedge system_clk) begin
    if (system_rst) begin
      frame_cnt <= 4'd0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 4'd1;
    end
  end

  assign wr_allowed_c = (ptr != LAST_ADDR);

  always_comb begin
    reg_bank = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_bank[8*i +: 8] = regs[i];
    reg_bank[8*(NUM_REGS-1) +: 8] = {err_count[3:0], frame_cnt};
  end
`else
  assign wr_allowed_c = 1'b1;

  always_comb begin
    reg_bank = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_bank[8*i +: 8] = regs[i];
  end
`endif

  // Frame parser. settle holds off WAIT_CS until the synchronizer reflects the pin.
  always_ff @(posedge system_clk) begin
    if (system_rst) begin
      state         <= ST_WAIT_CS;
      settle        <= 2'b00;
      ready_d       <= 1'b0;
      spi_read_ack  <= 1'b0;
      ptr           <= '0;
      rd_ptr        <= '0;
      err_count     <= 8'd0;
      reg_wr_strobe <= 1'b0;
      reg_wr_addr   <= '0;
      reg_wr_data   <= 8'd0;
      frame_done    <= 1'b0;
      data_to_send  <= RESET_VAL;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      settle        <= {settle[0], 1'b1};
      ready_d       <= spi_data_ready;
      spi_read_ack  <= consume_c;
      reg_wr_strobe <= 1'b0;
      frame_done    <= 1'b0;
      data_to_send  <= reg_bank[{rd_ptr, 3'b000} +: 8];

      case (state)
        ST_WAIT_CS: if (settle[1] && cs_n_s) state <= ST_IDLE;
        ST_IDLE:    if (cs_fall_c) state <= ST_CMD;
        ST_CMD: begin
          if (consume_c) begin
            if (addr_bad_c) begin
              if (err_count != ERR_MAX) err_count <= err_count + 8'd1;
              state <= ST_DISCARD;
            end else if (spi_rx_data[CMD_RD_BIT]) begin
              rd_ptr <= ADDR_W'(cmd_addr_c);
              state  <= ST_DISCARD;
            end else begin
              ptr   <= ADDR_W'(cmd_addr_c);
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (consume_c) begin
            if (wr_allowed_c) begin
              regs[ptr]     <= spi_rx_data;
              reg_wr_strobe <= 1'b1;
              reg_wr_addr   <= ptr;
              reg_wr_data   <= spi_rx_data;
            end
            ptr <= (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
          end
        end
        ST_DISCARD: state <= ST_DISCARD;
        default:    state <= ST_WAIT_CS;
      endcase

      // A byte arriving with the CS rise is handled above before the frame closes.
      if (cs_rise_c && in_frame_c) begin
        state      <= ST_IDLE;
        frame_done <= 1'b1;
      end
    end
  end

endmodule
